// File: rtl/axi_pkg.sv
// Shared definitions for the AXI traffic generator: FSM states, response codes
// and the saturating error-counter adder.
package axi_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAw,
        StW,
        StB,
        StAr,
        StR,
        StDone
    } tg_state_e;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlverr = 2'b10;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [2:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {14'b0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/axi_tg_pattern.sv
// Address/data pattern: burst start address for a transaction and the data
// word carried by a given beat of that burst.
module axi_tg_pattern
    import axi_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned BURST_LEN = 4
) (
    input  logic [15:0]       txn,
    input  logic [7:0]        beat,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);

    localparam int unsigned BeatBytes = DATA_W / 8;
    localparam int unsigned TxnBytes  = BURST_LEN * BeatBytes;

    logic [ADDR_W-1:0] beat_addr;

    // ADDR_W-wide arithmetic gives the required modulo-2^ADDR_W truncation.
    assign addr      = ADDR_W'(txn) * ADDR_W'(TxnBytes);
    assign beat_addr = addr + ADDR_W'(beat) * ADDR_W'(BeatBytes);
    assign data      = DATA_W'(beat_addr);

endmodule

// File: rtl/axi_traffic_gen.sv
// AXI write/read-back traffic generator: writes NUM_TXN incrementing bursts,
// reads each back, and counts response, data and rlast errors.
module axi_traffic_gen
    import axi_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned NUM_TXN   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              done,
    output logic [15:0]       err_cnt,
    output logic [ADDR_W-1:0] awaddr,
    output logic [7:0]        awlen,
    output logic              awvalid,
    input  logic              awready,
    output logic [DATA_W-1:0] wdata,
    output logic              wlast,
    output logic              wvalid,
    input  logic              wready,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready,
    output logic [ADDR_W-1:0] araddr,
    output logic [7:0]        arlen,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready
);

    localparam logic [7:0]  LastBeat = 8'(BURST_LEN - 1);
    localparam logic [15:0] LastTxn  = 16'(NUM_TXN - 1);

    tg_state_e         state_q, state_d;
    logic [15:0]       txn_q, txn_d;
    logic [7:0]        beat_q, beat_d;
    logic [15:0]       err_q, err_d;
    logic              done_q, done_d;
    logic [2:0]        err_inc;
    logic              err_clr;
    logic              last_beat;
    logic [DATA_W-1:0] exp_rdata;

    axi_tg_pattern #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .BURST_LEN(BURST_LEN)
    ) u_wr_pattern (
        .txn (txn_q),
        .beat(beat_q),
        .addr(awaddr),
        .data(wdata)
    );

    axi_tg_pattern #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .BURST_LEN(BURST_LEN)
    ) u_rd_pattern (
        .txn (txn_q),
        .beat(beat_q),
        .addr(araddr),
        .data(exp_rdata)
    );

    assign last_beat = (beat_q == LastBeat);
    assign awlen     = LastBeat;
    assign arlen     = LastBeat;
    assign wlast     = (state_q == StW) && last_beat;
    assign done      = done_q;
    assign err_cnt   = err_q;

    always_comb begin
        state_d = state_q;
        txn_d   = txn_q;
        beat_d  = beat_q;
        done_d  = done_q;
        err_inc = 3'd0;
        err_clr = 1'b0;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        bready  = 1'b0;
        arvalid = 1'b0;
        rready  = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StAw;
                    txn_d   = 16'd0;
                    beat_d  = 8'd0;
                    done_d  = 1'b0;
                    err_clr = 1'b1;
                end
            end
            StAw: begin
                awvalid = 1'b1;
                if (awready) begin
                    state_d = StW;
                    beat_d  = 8'd0;
                end
            end
            StW: begin
                wvalid = 1'b1;
                if (wready) begin
                    if (last_beat) begin
                        state_d = StB;
                        beat_d  = 8'd0;
                    end else begin
                        beat_d = beat_q + 8'd1;
                    end
                end
            end
            StB: begin
                bready = 1'b1;
                if (bvalid) begin
                    err_inc = 3'(bresp != RespOkay);
                    state_d = StAr;
                end
            end
            StAr: begin
                arvalid = 1'b1;
                if (arready) begin
                    state_d = StR;
                    beat_d  = 8'd0;
                end
            end
            StR: begin
                rready = 1'b1;
                if (rvalid) begin
                    err_inc = 3'(rresp != RespOkay) + 3'(rdata != exp_rdata)
                            + 3'(rlast != last_beat);
                    // Early rlast ends the burst; a missing one still ends it on the last beat.
                    if (rlast || last_beat) begin
                        beat_d = 8'd0;
                        if (txn_q == LastTxn) begin
                            state_d = StDone;
                            done_d  = 1'b1;
                        end else begin
                            txn_d   = txn_q + 16'd1;
                            state_d = StAw;
                        end
                    end else begin
                        beat_d = beat_q + 8'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        err_d = err_clr ? 16'd0 : sat_add16(err_q, err_inc);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            txn_q   <= 16'd0;
            beat_q  <= 8'd0;
            err_q   <= 16'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            txn_q   <= txn_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: doc/axi_traffic_gen.md
AXI_TRAFFIC_GEN -- requirements
Module: axi_traffic_gen

Interface
REQ-001 Parameter DATA_W, default 32: AXI data width in bits, a power of two and at least 8.
REQ-002 Parameter ADDR_W, default 32: AXI address width in bits.
REQ-003 Parameter BURST_LEN, default 4: beats per burst, range 1..256.
REQ-004 Parameter NUM_TXN, default 8: number of write/read-back bursts per run, range 1..65535.
REQ-005 Clock is clk, reset is rst_n; one clock; reset is synchronous and active-low.
REQ-006 clk  in  1  sole clock; all logic on rising edge.
REQ-007 rst_n  in  1  synchronous active-low reset.
REQ-008 start  in  1  one-cycle run request.
REQ-009 done  out  1  run complete; level signal.
REQ-010 err_cnt  out  16  saturating count of detected errors.
REQ-011 awaddr  out  ADDR_W  write burst start address.
REQ-012 awlen  out  8  write burst length; always BURST_LEN-1.
REQ-013 awvalid / awready  out / in  1 each  AW handshake.
REQ-014 wdata  out  DATA_W  write beat data.
REQ-015 wlast  out  1  final write beat.
REQ-016 wvalid / wready  out / in  1 each  W handshake.
REQ-017 bresp  in  2  write response.
REQ-018 bvalid / bready  in / out  1 each  B handshake.
REQ-019 araddr  out  ADDR_W  read burst start address.
REQ-020 arlen  out  8  read burst length; always BURST_LEN-1.
REQ-021 arvalid / arready  out / in  1 each  AR handshake.
REQ-022 rdata  in  DATA_W  read beat data.
REQ-023 rresp  in  2  read response.
REQ-024 rlast  in  1  final read beat.
REQ-025 rvalid / rready  in / out  1 each  R handshake.

Function
REQ-026 Bursts SHALL be INCR type with full-width beats; wstrb/size/burst/ID are not ports and are tied off by the integrator (all-ones strobe, size log2(DATA_W/8), INCR, ID 0).
REQ-027 FSM states SHALL be IDLE, AW, W, B, AR, R, DONE; start is honoured only in IDLE or DONE, which clears done, clears err_cnt, sets txn=0 and enters AW.
REQ-028 Txn t address SHALL be t*BURST_LEN*(DATA_W/8), truncated to ADDR_W; beat b data SHALL be (address + b*(DATA_W/8)) zero-extended/truncated to DATA_W.
REQ-029 AW->W on awvalid&&awready; W->B on the handshake of the beat with wlast=1; B->AR on bvalid&&bready; AR->R on arvalid&&arready; R->AW (txn+1) or ->DONE (after txn NUM_TXN-1) on the rvalid&&rready beat with rlast=1.
REQ-030 A valid SHALL stay asserted, with address/data/wlast stable, until its handshake completes; wvalid is asserted continuously in W (no self-inserted bubbles); bready=1 only in B; rready=1 only in R.
REQ-031 err_cnt SHALL increment by 1 for each: bresp!=0; rresp!=0; rdata mismatch against the REQ-028 pattern; rlast value differing from (beat==BURST_LEN-1). Increments per beat are cumulative and saturate at 16'hFFFF.
REQ-032 Extra R beats after an early rlast SHALL NOT occur (R is left on rlast); a missing rlast on beat BURST_LEN-1 counts one error and the FSM still leaves R on that beat.
REQ-033 done SHALL assert the cycle after entering DONE and hold until the next accepted start or reset.
REQ-034 Channels are strictly serialised: at most one valid asserted by the block at any time.

Reset
REQ-035 While rst_n=0 at a clk edge: state IDLE, all valid/ready outputs 0, done 0, err_cnt 0, txn and beat counters 0, awaddr/araddr/wdata 0, wlast 0.
REQ-036 Reset mid-operation SHALL abandon the burst without completing handshakes; the following start runs from txn 0.

Structure
REQ-037 The FSM state enumeration and AXI response codes (OKAY=2'b00) SHALL live in a shared package axi_pkg.
REQ-038 The address/data pattern SHALL be one sub-module axi_tg_pattern (txn, beat -> addr, data), instantiated once for the write and once for the read-compare path.

Verification
REQ-039 DATA_W=32, BURST_LEN=4, NUM_TXN=2, zero-wait memory slave, pulse start -> awaddr 0x00 then 0x10, wdata 0x0,0x4,0x8,0xC for txn 0, done=1, err_cnt=0.
REQ-040 wready low on alternate cycles -> wvalid held, wdata stable across stalls, 4 beats accepted, wlast only on the 4th, err_cnt=0.
REQ-041 Slave flips bit 0 of txn 1 beat 2 (expected 0x18) -> err_cnt=1 at done.
REQ-042 bresp=2'b10 on txn 0 -> err_cnt=1, run still completes with done=1.
REQ-043 rst_n low for one edge during txn 0 beat 2 -> all valids 0 and done 0 after that edge; a new start completes with err_cnt=0.
REQ-044 Force err_cnt-generating slave (all rresp=SLVERR) with NUM_TXN=20000, BURST_LEN=4 -> err_cnt saturates at 0xFFFF.
